// File: rtl/conv_layer_sched.sv
// Sequencing controller for the two-layer convolution engine: 3x3 tap walk over a
// WxW image, layer-0 result writes, then a 2x2 max-pool pass into layer 1.
module conv_layer_sched #(
   parameter int unsigned W  = 64,
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] iaddr,
   output logic          tap_vld,
   input  logic          tap_rdy,
   output logic [3:0]    tap_idx,
   output logic          tap_pad,
   output logic          tap_last,
   input  logic          acc_done,
   output logic          cwr,
   output logic [AW-1:0] caddr_wr,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   output logic [2:0]    csel,
   output logic          pool_vld,
   output logic          pool_first
);

   localparam int unsigned LW = $clog2(W);
   localparam int unsigned PN = 2 * LW;

   typedef enum logic [2:0] {
      IDLE, TAP, WAIT_ACC, WR0, POOL_RD, POOL_WT, WR1, DONE
   } state_t;

   state_t        state, state_n;
   // pix = {y,x} and pidx = {py,px}: raster order is a plain increment
   logic [PN-1:0] pix, pix_n;
   logic [PN-3:0] pidx, pidx_n;
   logic [3:0]    tap, tap_n;
   logic [1:0]    pc, pc_n;
   logic          rd_first, rd_first_n;

   logic          busy_n, done_n, tap_vld_n, tap_pad_n, tap_last_n;
   logic          cwr_n, crd_n, pool_vld_n, pool_first_n;
   logic [AW-1:0] iaddr_n, caddr_wr_n, caddr_rd_n;
   logic [3:0]    tap_idx_n;
   logic [2:0]    csel_n;

   logic [1:0]    ky, kx;
   logic [LW+1:0] ty, tx;
   logic          oob;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pix        <= '0;
         pidx       <= '0;
         tap        <= '0;
         pc         <= '0;
         rd_first   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         iaddr      <= '0;
         tap_vld    <= 1'b0;
         tap_idx    <= '0;
         tap_pad    <= 1'b0;
         tap_last   <= 1'b0;
         cwr        <= 1'b0;
         caddr_wr   <= '0;
         crd        <= 1'b0;
         caddr_rd   <= '0;
         csel       <= '0;
         pool_vld   <= 1'b0;
         pool_first <= 1'b0;
      end else begin
         state      <= state_n;
         pix        <= pix_n;
         pidx       <= pidx_n;
         tap        <= tap_n;
         pc         <= pc_n;
         rd_first   <= rd_first_n;
         busy       <= busy_n;
         done       <= done_n;
         iaddr      <= iaddr_n;
         tap_vld    <= tap_vld_n;
         tap_idx    <= tap_idx_n;
         tap_pad    <= tap_pad_n;
         tap_last   <= tap_last_n;
         cwr        <= cwr_n;
         caddr_wr   <= caddr_wr_n;
         crd        <= crd_n;
         caddr_rd   <= caddr_rd_n;
         csel       <= csel_n;
         pool_vld   <= pool_vld_n;
         pool_first <= pool_first_n;
      end
   end

   always_comb begin
      state_n = state;
      pix_n   = pix;
      pidx_n  = pidx;
      tap_n   = tap;
      pc_n    = pc;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = TAP;
               pix_n   = '0;
               tap_n   = '0;
            end
         end
         TAP: begin
            if (tap_vld && tap_rdy) begin
               if (tap == 4'd8) state_n = WAIT_ACC;
               else             tap_n   = tap + 4'd1;
            end
         end
         WAIT_ACC: begin
            if (acc_done) state_n = WR0;
         end
         WR0: begin
            pix_n = pix + PN'(1);
            if (&pix) begin
               state_n = POOL_RD;
               pidx_n  = '0;
               pc_n    = '0;
            end else begin
               state_n = TAP;
               tap_n   = '0;
            end
         end
         POOL_RD: begin
            pc_n = pc + 2'd1;
            if (pc == 2'd3) state_n = POOL_WT;
         end
         POOL_WT: state_n = WR1;
         WR1: begin
            pidx_n = pidx + (PN-2)'(1);
            if (&pidx) begin
               state_n = DONE;
            end else begin
               state_n = POOL_RD;
               pc_n    = '0;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // tap offset (ky,kx) = (dy+1,dx+1)
   always_comb begin
      ky = 2'd0;
      kx = 2'd0;
      case (tap_n)
         4'd0: begin ky = 2'd0; kx = 2'd0; end
         4'd1: begin ky = 2'd0; kx = 2'd1; end
         4'd2: begin ky = 2'd0; kx = 2'd2; end
         4'd3: begin ky = 2'd1; kx = 2'd0; end
         4'd4: begin ky = 2'd1; kx = 2'd1; end
         4'd5: begin ky = 2'd1; kx = 2'd2; end
         4'd6: begin ky = 2'd2; kx = 2'd0; end
         4'd7: begin ky = 2'd2; kx = 2'd1; end
         default: begin ky = 2'd2; kx = 2'd2; end
      endcase
   end

   // Two's complement in LW+2 bits; the result spans -1..W, so the sign bit flags
   // -1 and bit LW flags W, and an out-of-range coordinate never aliases in range.
   always_comb begin
      ty  = {2'b00, pix_n[PN-1:LW]} + {{LW{1'b0}}, ky} - (LW+2)'(1);
      tx  = {2'b00, pix_n[LW-1:0]}  + {{LW{1'b0}}, kx} - (LW+2)'(1);
      oob = ty[LW+1] | ty[LW] | tx[LW+1] | tx[LW];
   end

   // Outputs are decoded from next-state values so they register alongside the state.
   always_comb begin
      busy_n       = (state_n != IDLE);
      done_n       = (state_n == DONE);
      tap_vld_n    = (state_n == TAP);
      tap_idx_n    = tap_vld_n ? tap_n : 4'd0;
      tap_pad_n    = tap_vld_n && oob;
      tap_last_n   = tap_vld_n && (tap_n == 4'd8);
      iaddr_n      = (tap_vld_n && !oob) ? AW'({ty[LW-1:0], tx[LW-1:0]}) : '0;
      cwr_n        = (state_n == WR0) || (state_n == WR1);
      caddr_wr_n   = '0;
      if (state_n == WR0)      caddr_wr_n = AW'(pix_n);
      else if (state_n == WR1) caddr_wr_n = AW'(pidx_n);
      crd_n        = (state_n == POOL_RD);
      caddr_rd_n   = crd_n ? AW'({pidx_n[PN-3:LW-1], pc_n[1], pidx_n[LW-2:0], pc_n[0]}) : '0;
      csel_n       = 3'b000;
      if (state_n == WR1)                             csel_n = 3'b011;
      else if (state_n == WR0 || state_n == POOL_RD)  csel_n = 3'b001;
      rd_first_n   = crd_n && (pc_n == 2'd0);
      pool_vld_n   = crd;
      pool_first_n = rd_first;
   end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: a frame-level model fills expectation queues,
// a monitor pops them as taps are accepted and layer-memory strobes appear.
module tb_conv_layer_sched;

   localparam int W     = 8;
   localparam int AW    = 12;
   localparam int FRAME = W*W*11 + (W/2)*(W/2)*6 + 2;
   localparam int RSTPX = W*W/2 + 8;

   logic          clk, reset, start, busy, done;
   logic [AW-1:0] iaddr, caddr_wr, caddr_rd;
   logic          tap_vld, tap_rdy, tap_pad, tap_last, acc_done;
   logic [3:0]    tap_idx;
   logic          cwr, crd, pool_vld, pool_first;
   logic [2:0]    csel;

   conv_layer_sched #(.W(W), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .iaddr(iaddr), .tap_vld(tap_vld), .tap_rdy(tap_rdy), .tap_idx(tap_idx),
      .tap_pad(tap_pad), .tap_last(tap_last), .acc_done(acc_done), .cwr(cwr),
      .caddr_wr(caddr_wr), .crd(crd), .caddr_rd(caddr_rd), .csel(csel),
      .pool_vld(pool_vld), .pool_first(pool_first)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int addr; int idx; int pad; int last; } tap_t;
   typedef struct { int addr; int sel; } wr_t;
   tap_t tap_q[$];
   wr_t  wr_q[$];
   int   rd_q[$];
   int   first_q[$];

   int total = 0;
   int bad   = 0;
   bit rand_mode   = 1'b0;
   bit waiting     = 1'b0;
   bit acc_pending = 1'b0;
   int acc_dly     = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got unexpected/missing event, required none", name);
   endtask

   function automatic longint all_outs();
      return longint'({busy, done, iaddr, tap_vld, tap_idx, tap_pad, tap_last,
                       cwr, caddr_wr, crd, caddr_rd, csel, pool_vld, pool_first});
   endfunction

   // Reference frame: every tap, every layer write and every pool read in order.
   task automatic build_frame();
      for (int y = 0; y < W; y++) begin
         for (int x = 0; x < W; x++) begin
            for (int k = 0; k < 9; k++) begin
               int yy;
               int xx;
               int p;
               yy = y + k/3 - 1;
               xx = x + k%3 - 1;
               p  = (yy < 0 || yy >= W || xx < 0 || xx >= W) ? 1 : 0;
               tap_q.push_back('{p ? 0 : yy*W + xx, k, p, (k == 8) ? 1 : 0});
            end
            wr_q.push_back('{y*W + x, 1});
         end
      end
      for (int py = 0; py < W/2; py++) begin
         for (int px = 0; px < W/2; px++) begin
            for (int r = 0; r < 2; r++)
               for (int c = 0; c < 2; c++) begin
                  rd_q.push_back((2*py + r)*W + 2*px + c);
                  first_q.push_back((r == 0 && c == 0) ? 1 : 0);
               end
            wr_q.push_back('{py*(W/2) + px, 3});
         end
      end
   endtask

   // input drivers, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         tap_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!rand_mode) begin
            acc_done = 1'b1;
         end else if (acc_pending) begin
            if (acc_dly == 0) begin
               acc_done    = 1'b1;
               acc_pending = 1'b0;
            end else begin
               acc_done = 1'b0;
               acc_dly--;
            end
         end else begin
            acc_done = ($urandom_range(0, 3) == 0);
         end
      end
   end

   // monitor
   logic [AW-1:0] p_iaddr;
   logic [3:0]    p_idx;
   logic          p_pad, p_last, p_vld;

   initial begin
      p_iaddr = '0; p_idx = '0; p_pad = 1'b0; p_last = 1'b0; p_vld = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            p_iaddr = '0; p_idx = '0; p_pad = 1'b0; p_last = 1'b0; p_vld = 1'b0;
            waiting = 1'b0;
         end else begin
            if (waiting) begin
               if (acc_done) begin
                  chk("wr0_after_acc", longint'(cwr), 1);
                  waiting = 1'b0;
               end else begin
                  chk("no_cwr_in_wait", longint'(cwr), 0);
               end
            end
            if (p_vld && tap_rdy) begin
               if (tap_q.size() == 0) begin
                  fail("tap_extra");
               end else begin
                  tap_t e;
                  e = tap_q.pop_front();
                  chk("tap_iaddr", longint'(p_iaddr), e.addr);
                  chk("tap_idx",   longint'(p_idx),   e.idx);
                  chk("tap_pad",   longint'(p_pad),   e.pad);
                  chk("tap_last",  longint'(p_last),  e.last);
                  if (e.last != 0) begin
                     waiting     = 1'b1;
                     acc_dly     = int'($urandom_range(0, 5));
                     acc_pending = 1'b1;
                  end
               end
            end else if (p_vld && !tap_rdy) begin
               chk("stall_hold", longint'({tap_vld, iaddr, tap_idx, tap_pad, tap_last}),
                   longint'({1'b1, p_iaddr, p_idx, p_pad, p_last}));
            end
            if (cwr) begin
               if (wr_q.size() == 0) fail("cwr_extra");
               else begin
                  wr_t w;
                  w = wr_q.pop_front();
                  chk("caddr_wr", longint'(caddr_wr), w.addr);
                  chk("csel_wr",  longint'(csel),     w.sel);
               end
            end
            if (crd) begin
               if (rd_q.size() == 0) fail("crd_extra");
               else begin
                  chk("caddr_rd", longint'(caddr_rd), rd_q.pop_front());
                  chk("csel_rd",  longint'(csel),     1);
               end
            end
            if (pool_vld) begin
               if (first_q.size() == 0) fail("pool_vld_extra");
               else chk("pool_first", longint'(pool_first), first_q.pop_front());
            end
            if (!cwr && !crd) chk("csel_idle", longint'(csel), 0);
            p_iaddr = iaddr; p_idx = tap_idx; p_pad = tap_pad; p_last = tap_last; p_vld = tap_vld;
         end
      end
   end

   task automatic run_frame(input bit hold, input bit chklen);
      int cnt;
      build_frame();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("start_busy",    longint'(busy),    1);
      chk("start_tap_vld", longint'(tap_vld), 1);
      chk("start_tap_idx", longint'(tap_idx), 0);
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
      end
      cnt = 1;
      while (!done && cnt < 20000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      if (!done) begin
         fail("frame_timeout");
      end else begin
         if (chklen) chk("frame_len", cnt, FRAME - 1);
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
         #1;
         chk("done_pulse", longint'(done), 0);
         chk("busy_fall",  longint'(busy), 0);
      end
      chk("tap_q_left",   tap_q.size(),   0);
      chk("wr_q_left",    wr_q.size(),    0);
      chk("rd_q_left",    rd_q.size(),    0);
      chk("first_q_left", first_q.size(), 0);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; tap_rdy = 1'b0; acc_done = 1'b0;
      #1;
      chk("reset_outs", all_outs(), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      rand_mode = 1'b0;
      run_frame(1'b1, 1'b1);
      rand_mode = 1'b1;
      run_frame(1'b0, 1'b0);

      // reset during WR0 of a mid-frame pixel
      rand_mode = 1'b0;
      build_frame();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 20000) begin
         @(posedge clk);
         #2;
         if (cwr && csel == 3'b001 && caddr_wr == AW'(RSTPX)) break;
         n++;
      end
      if (n >= 20000) fail("rst_target_timeout");
      reset = 1'b1;
      #1;
      chk("rst_mid_outs", all_outs(), 0);
      tap_q.delete(); wr_q.delete(); rd_q.delete(); first_q.delete();
      waiting = 1'b0; acc_pending = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("no_wr_after_rst", longint'({cwr, busy}), 0);
      end

      rand_mode = 1'b1;
      run_frame(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_layer_sched.md
# conv_layer_sched

Sequencing controller for the two-layer convolution engine. On `start` it walks every output pixel of the W×W image. For each pixel it issues nine 3×3 tap fetches to the MAC datapath, with zero-padding flags. Once the MAC reports completion it writes the result to layer-0 memory, then runs a 2×2 max-pool pass that reads layer 0 and writes layer 1. It owns all image and layer-memory address, strobe and select generation; the MAC, bias/ReLU and pool-max arithmetic live in the datapath.

## Interface
Parameters:
- `W`, default 64, image width = height; power of two, ≥4.
- `AW`, default 12, address width; W*W ≤ 2^AW.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin a frame; sampled only in IDLE.
- `busy` out 1: high from the cycle after accepted `start` through DONE.
- `done` out 1: one-cycle pulse at frame end.
- `iaddr` out AW: image address of the current tap.
- `tap_vld` out 1: tap request valid.
- `tap_rdy` in 1: MAC accepts tap.
- `tap_idx` out 4: tap number 0..8, row-major (dy=-1..1 outer, dx=-1..1 inner).
- `tap_pad` out 1: tap is out of bounds; MAC uses 0 instead of `idata`.
- `tap_last` out 1: tap_idx==8.
- `acc_done` in 1: MAC result (bias+ReLU applied) is ready on `cdata_wr`.
- `cwr` out 1: layer-memory write strobe.
- `caddr_wr` out AW: write address.
- `crd` out 1: layer-memory read strobe.
- `caddr_rd` out AW: read address.
- `csel` out 3: memory select; 3'b001 = layer 0, 3'b011 = layer 1, 3'b000 = idle.
- `pool_vld` out 1: `cdata_rd` holds a pool sample this cycle.
- `pool_first` out 1: first of the four samples (pool unit reloads its max).

## Operation
- States: IDLE, TAP, WAIT_ACC, WR0, POOL_RD, POOL_WT, WR1, DONE.
- IDLE:
  - `start`=1 → TAP with pixel (y,x)=(0,0) and tap 0.
  - `start` in any other state is ignored.
- TAP:
  - `tap_vld`=1.
  - Tap k uses dy=k/3-1, dx=k%3-1.
  - If y+dy or x+dx lies outside 0..W-1: `tap_pad`=1 and `iaddr`=0.
  - Otherwise `iaddr`=(y+dy)*W+(x+dx).
  - Tap advances only on `tap_vld`&`tap_rdy`; outputs are held while `tap_rdy`=0.
  - Tap 8 accepted → WAIT_ACC.
- WAIT_ACC: `tap_vld`=0; wait for `acc_done`. `acc_done` outside WAIT_ACC is ignored.
- WR0 (one cycle):
  - `cwr`=1, `csel`=001, `caddr_wr`=y*W+x.
  - Then advance x; x wraps at W-1 and increments y.
  - Pixel W*W-1 written → POOL_RD with (py,px)=(0,0); otherwise → TAP with tap 0.
- POOL_RD (4 cycles):
  - `crd`=1, `csel`=001.
  - `caddr_rd` sequence: (2py,2px), (2py,2px+1), (2py+1,2px), (2py+1,2px+1), address = row*W+col.
  - `pool_vld` is `crd` delayed one cycle; `pool_first` marks the sample from the first read.
- POOL_WT (one cycle): `crd`=0; `pool_vld`=1 for the 4th sample.
- WR1 (one cycle):
  - `cwr`=1, `csel`=011, `caddr_wr`=py*(W/2)+px.
  - Advance px/py raster.
  - Last pooled output (W/2)²-1 → DONE; otherwise → POOL_RD.
- DONE (one cycle): `done`=1, then IDLE with `busy`=0.
- `csel`=000 whenever `cwr`=0 and `crd`=0.

## Timing
- All outputs are registered.
- Reset value of every output is 0: `busy`, `done`, `iaddr`, `tap_vld`, `tap_idx`, `tap_pad`, `tap_last`, `cwr`, `caddr_wr`, `crd`, `caddr_rd`, `csel`, `pool_vld`, `pool_first`.
- Reset asserted mid-frame: all outputs return to 0 and the FSM goes to IDLE immediately. No further write strobe may occur until a new `start`.
- Start latency: `start` high in cycle n → `busy`=1 and `tap_vld`=1 (tap 0, pixel 0) in cycle n+1.
- Per-pixel latency with `tap_rdy`=1:
  - 9 TAP cycles.
  - WAIT_ACC lasts until `acc_done` (minimum 1 cycle if `acc_done` is high on entry).
  - Then 1 WR0 cycle.
- Per pooled output: 6 cycles (4 read, 1 wait, 1 write).
- Total frame with `tap_rdy`=1 and `acc_done` immediate: W²·11 + (W/2)²·6 + 2 cycles after `start`.
- Address arithmetic is unsigned AW-bit. Boundary checks use signed comparison of y+dy and x+dx before forming the address; wrap-around must never produce a wrong in-bounds address.

## Test plan
- **Corner padding, W=64, `tap_rdy`=`acc_done`=1.**
  - Pixel (0,0): `tap_pad` pattern 1,1,1,1,0,0,1,0,0 with `iaddr` 0,0,0,0,0,1,0,64,65.
  - Pixel (63,63): last taps pad on 2,5,6,7,8, with `iaddr`(tap 0)=4030.
- **Backpressure.** Toggle `tap_rdy` randomly.
  - Check each tap_idx 0..8 is accepted exactly once per pixel.
  - Check `iaddr`, `tap_pad` and `tap_last` stay stable while stalled.
- **Layer-0 writes.** Delay `acc_done` 0–5 cycles.
  - Expect 4096 `cwr` pulses with `csel`=001 and `caddr_wr` 0..4095 in order.
  - No `cwr` while in WAIT_ACC.
- **Pool pass, W=4.**
  - Reads for output 0: addresses 0,1,4,5; output 3: 10,11,14,15.
  - `pool_first` on the first sample of each output.
  - WR1 addresses 0..3 with `csel`=011.
- **Frame end.**
  - `done` is a single pulse; `busy` falls the next cycle.
  - With W=4, the frame length is exactly 4²·11 + 2²·6 + 2 = 202 cycles.
  - `start` held high during the frame causes no restart.
- **Reset mid-frame.** Assert `reset` during WR0 of pixel 100.
  - All outputs are 0 the same cycle.
  - A fresh `start` restarts at pixel 0, tap 0.
